// File: rtl/apb_timer.sv
// APB completer exposing a prescaled 32-bit down-counter timer.
// Four registers: CTRL, LOAD, COUNT (read-only), STATUS (W1C expiry flag).
// Bus responses are Moore outputs of the transfer FSM, the wait counter
// and the registers; address and direction are captured at SETUP.
module apb_timer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]           PWDATA,
   output logic [31:0]           PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic                  irq
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   state_t                state, state_next;
   logic [3:0]            wait_cnt, wait_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;

   // timer registers
   logic        en, auto_reload, irq_en;
   logic [7:0]  prescale;
   logic [7:0]  presc_cnt;
   logic [31:0] load_val;
   logic [31:0] count;
   logic        expired;

   logic        ready, addr_bad, err, complete, wr_ok;
   logic [1:0]  reg_sel;
   logic        wr_ctrl, wr_load, wr_status;
   logic        tick_raw, tick;
   logic [31:0] rd_mux;

   // Next-state logic of the transfer FSM and its wait-state counter.
   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_next = ACCESS;
               wait_next  = WAIT_INIT;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               // aborted transfer: drop back without touching any register
               state_next = IDLE;
            end else if (wait_cnt == 4'd0) begin
               if (PENABLE) state_next = IDLE;
            end else begin
               wait_next = wait_cnt - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state, wait counter and the address/direction captured at SETUP.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         if (state == IDLE && PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
         end
      end
   end

   // Decode of the captured transfer and the completing-edge write strobes.
   always_comb begin
      reg_sel   = addr_q[3:2];
      addr_bad  = (addr_q[1:0] != 2'd0) || (|addr_q[ADDR_WIDTH-1:4]);
      err       = addr_bad || (write_q && reg_sel == REG_COUNT);
      ready     = (state == ACCESS) && (wait_cnt == 4'd0);
      complete  = ready && PSEL && PENABLE;
      wr_ok     = complete && write_q && !err;
      wr_ctrl   = wr_ok && (reg_sel == REG_CTRL);
      wr_load   = wr_ok && (reg_sel == REG_LOAD);
      wr_status = wr_ok && (reg_sel == REG_STATUS);
   end

   // Read mux and bus outputs; data and error are forced to 0 outside a ready cycle.
   always_comb begin
      rd_mux = 32'd0;
      case (reg_sel)
         REG_CTRL:   rd_mux = {16'd0, prescale, 5'd0, irq_en, auto_reload, en};
         REG_LOAD:   rd_mux = load_val;
         REG_COUNT:  rd_mux = count;
         REG_STATUS: rd_mux = {31'd0, expired};
         default:    rd_mux = 32'd0;
      endcase
      PREADY  = ready;
      PSLVERR = ready && err;
      PRDATA  = (ready && !write_q && !err) ? rd_mux : 32'd0;
   end

   // Tick on prescaler wrap while enabled; a CTRL write clearing EN on the
   // same edge cancels it. The >= compare recovers if PRESCALE is lowered
   // below the running prescaler value.
   always_comb begin
      tick_raw = en && (presc_cnt >= prescale);
      tick     = tick_raw && !(wr_ctrl && !PWDATA[0]);
   end

   // Timer registers: bus writes, prescaler, down-counter and expiry flag.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         en          <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
         prescale    <= 8'd0;
         presc_cnt   <= 8'd0;
         load_val    <= 32'd0;
         count       <= 32'd0;
         expired     <= 1'b0;
      end else begin
         if (wr_load || !en || presc_cnt >= prescale) begin
            presc_cnt <= 8'd0;
         end else begin
            presc_cnt <= presc_cnt + 8'd1;
         end

         if (wr_ctrl) begin
            en          <= PWDATA[0];
            auto_reload <= PWDATA[1];
            irq_en      <= PWDATA[2];
            prescale    <= PWDATA[15:8];
         end else if (tick && count == 32'd0 && !auto_reload) begin
            en <= 1'b0;
         end

         if (wr_load) load_val <= PWDATA;

         // a LOAD write overrides the tick's effect on COUNT
         if (wr_load) begin
            count <= PWDATA;
         end else if (tick) begin
            if (count != 32'd0)   count <= count - 32'd1;
            else if (auto_reload) count <= load_val;
         end

         // expiry set takes priority over a same-edge W1C
         if (tick && count == 32'd0) begin
            expired <= 1'b1;
         end else if (wr_status && PWDATA[0]) begin
            expired <= 1'b0;
         end
      end
   end

   // Interrupt is a gate of two flops, so it cannot glitch on bus activity.
   assign irq = expired & irq_en;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: a table of APB transactions with
// hand-computed responses, plus sequences for reset, interrupt timing,
// W1C/expiry collision and an aborted transfer.
module tb_apb_timer;

   localparam int ADDR_WIDTH  = 8;
   localparam int WAIT_STATES = 1;

   logic                  PCLK;
   logic                  PRESET;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [31:0]           PWDATA;
   logic [31:0]           PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   logic                  irq;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          idle;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
      string       name;
   } vec_t;

   vec_t vecs[$];

   apb_timer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WAIT_STATES(WAIT_STATES)
   ) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .PSEL   (PSEL),
      .PENABLE(PENABLE),
      .PWRITE (PWRITE),
      .PADDR  (PADDR),
      .PWDATA (PWDATA),
      .PRDATA (PRDATA),
      .PREADY (PREADY),
      .PSLVERR(PSLVERR),
      .irq    (irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input int idle, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input bit exp_err, input string name);
      vec_t v;
      v.idle = idle; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   // One complete APB transfer, started just after a rising edge; returns
   // just after the completing edge so a following call is back-to-back.
   task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int waits, output bit timeout);
      rdata = 32'd0; err = 1'b0; waits = 0; timeout = 1'b1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PREADY) begin
            rdata = PRDATA; err = PSLVERR; timeout = 1'b0;
            break;
         end
         waits++;
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
   endtask

   task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wdata, input string name);
      logic [31:0] rd; logic er; int w; bit to;
      xfer(1'b1, addr, wdata, rd, er, w, to);
      check({name, "_timeout"}, 32'(to), 32'd0);
      check({name, "_err"}, 32'(er), 32'd0);
   endtask

   task automatic rd_reg(input logic [7:0] addr, input logic [31:0] exp, input string name);
      logic [31:0] rd; logic er; int w; bit to;
      xfer(1'b0, addr, 32'd0, rd, er, w, to);
      check({name, "_timeout"}, 32'(to), 32'd0);
      check({name, "_rdata"}, rd, exp);
   endtask

   // Wait for irq high, sampling on falling edges; reports the edge count.
   task automatic wait_irq(output int rise, output bit timeout);
      timeout = 1'b1; rise = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge PCLK);
         if (irq) begin
            rise = cyc; timeout = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          w, t0, rise;
      bit          to;

      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;

      // ---- transaction table (register file, one-shot timing, errors) ----
      add(0, 0, 8'h00, 32'h0,          32'h0,         0, "ctrl_reset");
      add(0, 0, 8'h04, 32'h0,          32'h0,         0, "load_reset");
      add(0, 0, 8'h08, 32'h0,          32'h0,         0, "count_reset");
      add(0, 0, 8'h0C, 32'h0,          32'h0,         0, "status_reset");
      add(0, 1, 8'h00, 32'hA5A5_5AF8,  32'h0,         0, "ctrl_wr_mask");
      add(0, 0, 8'h00, 32'h0,          32'h0000_5A00, 0, "ctrl_rd_mask");
      add(0, 1, 8'h00, 32'h0,          32'h0,         0, "ctrl_clr");
      add(0, 1, 8'h04, 32'h3,          32'h0,         0, "load3");
      add(0, 0, 8'h04, 32'h0,          32'h3,         0, "load_rd");
      add(0, 0, 8'h08, 32'h0,          32'h3,         0, "count_eq_load");
      add(0, 1, 8'h00, 32'h1,          32'h0,         0, "ctrl_en");          // edge T
      add(1, 0, 8'h0C, 32'h0,          32'h0,         0, "status_at_t3");     // sees T+3
      add(0, 0, 8'h08, 32'h0,          32'h0,         0, "count_zero");       // sees T+6
      add(0, 0, 8'h0C, 32'h0,          32'h1,         0, "status_expired");
      add(0, 0, 8'h00, 32'h0,          32'h0,         0, "ctrl_en_cleared");
      add(0, 0, 8'h08, 32'h0,          32'h0,         0, "count_holds");
      add(0, 1, 8'h0C, 32'h1,          32'h0,         0, "status_w1c");
      add(0, 0, 8'h0C, 32'h0,          32'h0,         0, "status_cleared");
      add(0, 1, 8'h04, 32'h3,          32'h0,         0, "load3_b");
      add(0, 1, 8'h00, 32'h1,          32'h0,         0, "ctrl_en_b");        // edge T
      add(2, 0, 8'h0C, 32'h0,          32'h1,         0, "status_at_t4");     // sees T+4
      add(0, 1, 8'h04, 32'h3,          32'h0,         0, "load3_c");
      add(0, 1, 8'h00, 32'h1,          32'h0,         0, "ctrl_en_c");        // edge T
      add(0, 0, 8'h08, 32'h0,          32'h1,         0, "count_at_t2");      // sees T+2
      add(0, 1, 8'h04, 32'h7,          32'h0,         0, "load7");            // after expiry
      add(0, 0, 8'h10, 32'h0,          32'h0,         1, "err_rd_0x10");
      add(0, 1, 8'h08, 32'hFFFF_FFFF,  32'h0,         1, "err_wr_count");
      add(0, 0, 8'h08, 32'h0,          32'h7,         0, "count_unchanged");
      add(0, 0, 8'h02, 32'h0,          32'h0,         1, "err_rd_0x2");
      add(0, 1, 8'h02, 32'h5,          32'h0,         1, "err_wr_0x2");
      add(0, 0, 8'h00, 32'h0,          32'h0,         0, "ctrl_unchanged");
      add(0, 1, 8'h80, 32'h1,          32'h0,         1, "err_wr_0x80");
      add(0, 0, 8'h00, 32'h0,          32'h0,         0, "ctrl_unchanged_b");
      add(0, 0, 8'h04, 32'h0,          32'h7,         0, "load_unchanged");

      // ---- reset state ----
      #1;
      check("rst_pready",  32'(PREADY),  32'd0);
      check("rst_prdata",  PRDATA,       32'd0);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("rst_irq",     32'(irq),     32'd0);
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;

      // ---- reset in the ready ACCESS cycle of a LOAD write ----
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h55;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      check("midrst_wait_low", 32'(PREADY), 32'd0);
      @(posedge PCLK); #1;
      check("midrst_ready_high", 32'(PREADY), 32'd1);
      PRESET = 1'b1;
      #1;
      check("midrst_pready_drop", 32'(PREADY), 32'd0);
      check("midrst_pslverr", 32'(PSLVERR), 32'd0);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      PRESET = 1'b0;
      @(posedge PCLK); #1;

      // ---- table ----
      foreach (vecs[i]) begin
         idle_cycles(vecs[i].idle);
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w, to);
         check({vecs[i].name, "_timeout"}, 32'(to), 32'd0);
         check({vecs[i].name, "_waits"},   32'(w),  32'(WAIT_STATES));
         check({vecs[i].name, "_rdata"},   rd,      vecs[i].exp_rdata);
         check({vecs[i].name, "_pslverr"}, 32'(er), 32'(vecs[i].exp_err));
      end

      // ---- auto-reload interrupt period: (1+1)*(2+1) = 6 cycles ----
      wr_reg(8'h0C, 32'h1, "irq_pre_w1c");
      wr_reg(8'h04, 32'h1, "irq_load");
      wr_reg(8'h00, 32'h0000_0207, "irq_ctrl");
      t0 = cyc;
      check("irq_low_after_ctrl", 32'(irq), 32'd0);
      wait_irq(rise, to);
      check("irq_first_timeout", 32'(to), 32'd0);
      check("irq_first_rise", 32'(rise - t0), 32'd6);
      @(posedge PCLK); #1;
      wr_reg(8'h0C, 32'h1, "irq_w1c_a");
      check("irq_dropped_after_w1c", 32'(irq), 32'd0);
      wait_irq(rise, to);
      check("irq_second_timeout", 32'(to), 32'd0);
      check("irq_second_rise", 32'(rise - t0), 32'd12);
      @(posedge PCLK); #1;
      wr_reg(8'h0C, 32'h1, "irq_w1c_b");
      check("irq_low_before_collision", 32'(irq), 32'd0);

      // ---- W1C completing on the expiry edge T+24: set wins ----
      do begin
         @(posedge PCLK); #1;
      end while (cyc < t0 + 21);
      wr_reg(8'h0C, 32'h1, "collide_w1c");
      check("collide_irq_high", 32'(irq), 32'd1);
      rd_reg(8'h0C, 32'h1, "collide_status");
      wr_reg(8'h00, 32'h0, "irq_stop");
      wr_reg(8'h0C, 32'h1, "irq_final_w1c");
      check("irq_final_low", 32'(irq), 32'd0);

      // ---- PSEL dropped during a wait cycle of a LOAD write ----
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'hDEAD_BEEF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      check("abort_wait_low", 32'(PREADY), 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      check("abort_fsm_idle", 32'(PREADY), 32'd0);
      PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      xfer(1'b0, 8'h04, 32'd0, rd, er, w, to);
      check("abort_next_timeout", 32'(to), 32'd0);
      check("abort_next_waits", 32'(w), 32'(WAIT_STATES));
      check("abort_load_unchanged", rd, 32'h1);
      check("abort_next_pslverr", 32'(er), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
